// File: rtl/wreq_split_mc.sv
// wreq_split_mc: multi-channel DMA write-request segmenter.
// Round-robin packet arbitration over NUM_CH input streams; cuts each
// write packet into TLPs at max payload size and 4KB address boundaries,
// emitting tag-stamped AXIS write requests. Interrupt packets pass as
// a single beat.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   max_pyld_sz         MPS code (0=128B .. 5=4096B, >5 = 4096B)
//   in_valid/last/head/data, in_ready    per-channel input streams
//   axis_wr_req_*       output request stream (tdata/tuser/tkeep/tlast)
//   err_pulse           one-cycle pulse when a packet is dropped
//   stat_tlp_cnt, stat_drop_cnt  only with PCIEI_WREQ_STAT_EN defined
module wreq_split_mc #(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 256,
    parameter int HEAD_W  = 128,
    parameter int TUSER_W = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               max_pyld_sz,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        in_last,
    input  logic [NUM_CH*HEAD_W-1:0] in_head,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     axis_wr_req_tvalid,
    output logic                     axis_wr_req_tlast,
    output logic [DATA_W-1:0]        axis_wr_req_tdata,
    output logic [TUSER_W-1:0]       axis_wr_req_tuser,
    output logic [DATA_W/32-1:0]     axis_wr_req_tkeep,
    input  logic                     axis_wr_req_tready,
`ifdef PCIEI_WREQ_STAT_EN
    output logic [31:0]              stat_tlp_cnt,
    output logic [15:0]              stat_drop_cnt,
`endif
    output logic                     err_pulse
);

    localparam int KEEP_W = DATA_W / 32;
    localparam int BYTES  = DATA_W / 8;
    localparam int BSH    = $clog2(BYTES);
    localparam int KSH    = $clog2(KEEP_W);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [3:0] T_WR  = 4'h1;
    localparam logic [3:0] T_INT = 4'h2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEG,
        S_DATA,
        S_INT,
        S_DROP
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [CH_W-1:0]     gnt;
    logic [CH_W-1:0]     rr;
    logic [3:0]          typ;
    logic [63:0]         addr;
    logic [12:0]         rem;
    logic [2:0]          mps;
    logic [12:0]         cnt;
    logic [7:0]          tag;
    logic [TUSER_W-1:0]  tuser_q;
    logic [KEEP_W-1:0]   keep_last;
    logic                err_q;

    logic                arb_found;
    logic [CH_W-1:0]     arb_idx;
    logic [HEAD_W-1:0]   hd;
    logic                sel_valid;
    logic                sel_last;
    logic [DATA_W-1:0]   sel_data;
    logic                hs;
    logic [CH_W-1:0]     rr_nxt;

    logic [12:0]         mps_bytes;
    logic [12:0]         to_mps;
    logic [12:0]         to_4k;
    logic [12:0]         chunk;
    logic [10:0]         dwlen;
    logic [13:0]         beats_w;
    logic [KSH-1:0]      remdw;
    logic [KEEP_W-1:0]   keep_calc;
    logic                bad;
    logic [TUSER_W-1:0]  tuser_wr;
    logic [TUSER_W-1:0]  tuser_int;
    logic                tlp_done;
    logic                unused_bits;

    assign hd        = in_head[arb_idx*HEAD_W +: HEAD_W];
    assign sel_valid = in_valid[gnt];
    assign sel_last  = in_last[gnt];
    assign sel_data  = in_data[gnt*DATA_W +: DATA_W];
    assign hs        = sel_valid && axis_wr_req_tready;
    assign rr_nxt    = (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
    assign err_pulse = err_q;
    assign tlp_done  = hs && ((state == S_DATA && cnt == 13'd1) ||
                              state == S_INT);

    // First valid channel at or after the round-robin pointer.
    always_comb begin
        int c;
        c         = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = (int'(rr) + i) % NUM_CH;
            if (!arb_found && in_valid[c]) begin
                arb_found = 1'b1;
                arb_idx   = CH_W'(c);
            end
        end
    end

    // Chunk = min(remaining, bytes to MPS boundary, bytes to 4KB boundary).
    always_comb begin
        unique case (mps)
            3'd0:    mps_bytes = 13'd128;
            3'd1:    mps_bytes = 13'd256;
            3'd2:    mps_bytes = 13'd512;
            3'd3:    mps_bytes = 13'd1024;
            3'd4:    mps_bytes = 13'd2048;
            default: mps_bytes = 13'd4096;
        endcase
        to_mps = mps_bytes - (addr[12:0] & (mps_bytes - 13'd1));
        to_4k  = 13'h1000 - {1'b0, addr[11:0]};
        chunk  = rem;
        if (to_mps < chunk) chunk = to_mps;
        if (to_4k < chunk) chunk = to_4k;
        dwlen   = chunk[12:2];
        beats_w = ({1'b0, chunk} + 14'(BYTES - 1)) >> BSH;
        remdw   = dwlen[KSH-1:0];
        for (int i = 0; i < KEEP_W; i++) begin
            keep_calc[i] = (remdw == '0) || (KSH'(i) < remdw);
        end
    end

    always_comb begin
        bad = 1'b0;
        if (typ == T_WR) begin
            bad = (rem == 13'd0) || (addr[BSH-1:0] != '0) ||
                  (rem[1:0] != 2'd0);
        end else if (typ != T_INT) begin
            bad = 1'b1;
        end
    end

    always_comb begin
        tuser_wr           = '0;
        tuser_wr[107:104]  = typ;
        tuser_wr[103:96]   = tag;
        tuser_wr[95:32]    = addr;
        tuser_wr[18:8]     = dwlen;
        tuser_wr[7:4]      = 4'hF;
        tuser_wr[3:0]      = (dwlen == 11'd1) ? 4'h0 : 4'hF;
        tuser_int          = '0;
        tuser_int[107:104] = typ;
        tuser_int[95:32]   = addr;
    end

    assign unused_bits = ^{hd[HEAD_W-1:100], hd[31:13], beats_w[13]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            gnt       <= '0;
            rr        <= '0;
            typ       <= '0;
            addr      <= '0;
            rem       <= '0;
            mps       <= '0;
            cnt       <= '0;
            tag       <= '0;
            tuser_q   <= '0;
            keep_last <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_n;
            err_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (arb_found) begin
                        gnt  <= arb_idx;
                        typ  <= hd[99:96];
                        addr <= hd[95:32];
                        rem  <= hd[12:0];
                        mps  <= max_pyld_sz;
                    end
                end
                S_SEG: begin
                    if (bad) begin
                        err_q <= 1'b1;
                    end else if (typ == T_WR) begin
                        tuser_q   <= tuser_wr;
                        addr      <= addr + {51'd0, chunk};
                        rem       <= rem - chunk;
                        cnt       <= beats_w[12:0];
                        keep_last <= keep_calc;
                    end else begin
                        tuser_q <= tuser_int;
                    end
                end
                S_DATA: begin
                    if (hs) begin
                        cnt <= cnt - 13'd1;
                        if (cnt == 13'd1) begin
                            tag <= tag + 8'd1;
                            if (rem == 13'd0) rr <= rr_nxt;
                        end
                    end
                end
                S_INT: begin
                    if (hs) rr <= rr_nxt;
                end
                S_DROP: begin
                    if (sel_valid && sel_last) rr <= rr_nxt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n            = state;
        in_ready           = '0;
        axis_wr_req_tvalid = 1'b0;
        axis_wr_req_tlast  = 1'b0;
        axis_wr_req_tdata  = '0;
        axis_wr_req_tuser  = '0;
        axis_wr_req_tkeep  = '0;
        unique case (state)
            S_IDLE: begin
                if (arb_found) state_n = S_SEG;
            end
            S_SEG: begin
                if (bad) state_n = S_DROP;
                else if (typ == T_WR) state_n = S_DATA;
                else state_n = S_INT;
            end
            S_DATA: begin
                in_ready[gnt]      = axis_wr_req_tready;
                axis_wr_req_tvalid = sel_valid;
                axis_wr_req_tdata  = sel_data;
                axis_wr_req_tuser  = tuser_q;
                axis_wr_req_tlast  = (cnt == 13'd1);
                axis_wr_req_tkeep  = (cnt == 13'd1) ? keep_last : '1;
                if (hs && cnt == 13'd1) begin
                    state_n = (rem == 13'd0) ? S_IDLE : S_SEG;
                end
            end
            S_INT: begin
                in_ready[gnt]      = axis_wr_req_tready;
                axis_wr_req_tvalid = sel_valid;
                axis_wr_req_tdata  = sel_data;
                axis_wr_req_tuser  = tuser_q;
                axis_wr_req_tlast  = 1'b1;
                axis_wr_req_tkeep  = '1;
                if (hs) state_n = S_IDLE;
            end
            S_DROP: begin
                in_ready[gnt] = 1'b1;
                if (sel_valid && sel_last) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

`ifdef PCIEI_WREQ_STAT_EN
    logic [31:0] tlp_cnt;
    logic [15:0] drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tlp_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (tlp_done && tlp_cnt != '1) tlp_cnt <= tlp_cnt + 32'd1;
            if (state == S_SEG && bad && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign stat_tlp_cnt  = tlp_cnt;
    assign stat_drop_cnt = drop_cnt;
`else
    logic unused_stat;
    assign unused_stat = tlp_done;
`endif

endmodule
